game_turn_controller: RTL and testbench
=======================================

Name: game_turn_controller

Overview:
- Parametrised successor of the two-player game FSM; sequences a board game for NUM_PLAYERS players (idle, move wait, insert, win check, game over) with round-robin turns.
- Owns its own per-turn countdown (prescaler plus seconds counter) and move counter for draw detection.
- Uses req/ack handshakes with the board and win-checker blocks.
- Sits between player input decoders and the board/VGA/7-segment logic.

Parameters:
- NUM_PLAYERS, 2, players in rotation (2..7); ids 1..NUM_PLAYERS, 0 = none.
- COLS, 7, board columns.
- ROWS, 6, board rows; draw once ROWS*COLS pieces are placed.
- TURN_SECS, 10, seconds per turn (1..15).
- TICKS_PER_SEC, 50_000_000, clk cycles per second.
- Derived localparams: PID_W=$clog2(NUM_PLAYERS+1), COL_W=$clog2(COLS), MV_W=$clog2(ROWS*COLS+1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  pulse: leave IDLE and begin game
- fsm_reset  in  1  level: abort or restart game from any state
- move_valid  in  1  pulse: current player submitted move_col
- move_col  in  COL_W  column of submitted move
- insert_ack  in  1  board finished insertion (pulse)
- insert_ok  in  1  qualifies insert_ack; 0 = column full, nothing placed
- check_done  in  1  win checker finished (pulse)
- win_flag  in  1  qualifies check_done; winner present
- winner_id  in  PID_W  winning player id, valid with win_flag
- turn  out  PID_W  current player; 0 in IDLE/CLEAR
- enable_input  out  1  high in WAIT_MOVE only
- insert_req  out  1  held in INSERT until insert_ack
- insert_col  out  COL_W  registered column, stable while insert_req
- insert_player  out  PID_W  equals turn during INSERT
- check_req  out  1  held in CHECK until check_done
- status  out  8  0x00 none, 0x01..0x07 player N wins, 0x0F draw
- game_over  out  1  high in GAME_OVER
- reset_board  out  1  one-cycle pulse in CLEAR
- seg_value  out  4  remaining seconds; valid when seg_enable
- seg_enable  out  1  high in WAIT_MOVE
- move_count  out  MV_W  pieces placed this game

Behaviour:
- Reset (rst=0): state IDLE; all outputs 0; move_count=0; timer=TURN_SECS, prescaler=0.
- States: IDLE, WAIT_MOVE, INSERT, CHECK, GAME_OVER, CLEAR.
- IDLE: on start go to WAIT_MOVE, turn=1, timer loaded to TURN_SECS.
- WAIT_MOVE:
  - Prescaler counts 0..TICKS_PER_SEC-1; at wrap, seconds counter decrements.
  - Timeout is when seconds==0 at prescaler wrap.
  - move_valid: latch move_col, go to INSERT.
  - move_valid and timeout in the same cycle: move_valid wins.
  - Timeout handling depends on AUTO_MOVE_EN (see Optional Feature).
- INSERT: insert_req held. Extra move_valid pulses are ignored.
  - insert_ack with insert_ok=1: move_count+1, go to CHECK.
  - insert_ack with insert_ok=0 on a player move: return to WAIT_MOVE with the same turn, timer NOT reloaded.
- CHECK: check_req held until check_done.
  - win_flag=1: status=winner_id, go to GAME_OVER.
  - Else if move_count==ROWS*COLS: status=0x0F, go to GAME_OVER.
  - Else: turn = (turn==NUM_PLAYERS) ? 1 : turn+1, reload timer, go to WAIT_MOVE.
- Latency: move_valid to insert_req is 1 cycle. check_done to next-turn enable_input is 1 cycle.
- GAME_OVER: status and game_over held; wait for fsm_reset.
- CLEAR:
  - Entered on fsm_reset=1 from any non-IDLE state, with priority over every other transition.
  - reset_board pulses one cycle; move_count, status and timer cleared/reloaded.
  - Next state IDLE; holding fsm_reset keeps the block in IDLE.
- seg_value=seconds counter in WAIT_MOVE, else 0.

Optional Feature:
- Macro: GAME_AUTO_MOVE_EN.
- Defined:
  - Timeout inserts automatically; column comes from an internal 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 0xA5, advances every cycle), taken mod COLS.
  - On insert_ok=0, column = (col+1) wrap COLS and retry, up to COLS attempts.
  - If all COLS attempts fail: status=0x0F, go to GAME_OVER.
- Undefined: timeout skips the turn; advance to the next player, timer reloaded, move_count unchanged, no insert.

Decomposition:
- game_pkg: state_t enum, STATUS_NONE/STATUS_DRAW constants, LFSR seed/taps.
- Sub-module turn_timer: prescaler plus seconds down-counter.
  - Inputs: load, run. Outputs: secs, timeout pulse.
  - Instantiated once.

Test Plan:
- Reset then start; P1 move_col=3, insert_ack/ok, check_done win=0 -> insert_col=3, move_count=1, turn=2, seg_value=10.
- Small TICKS_PER_SEC=4, TURN_SECS=2, no move:
  - Macro undefined: turn 1->2 after 12 cycles in WAIT_MOVE, move_count=0.
  - Macro defined: insert_req asserted with LFSR-derived column.
- insert_ok=0 on P2 move at seg_value=5 -> back to WAIT_MOVE, turn=2, seg_value still 5.
- NUM_PLAYERS=3: three non-winning moves -> turn 1,2,3,1; win_flag with winner_id=3 -> status=0x03, game_over=1.
- ROWS=1, COLS=2: two non-winning moves -> status=0x0F.
- fsm_reset asserted during INSERT and during GAME_OVER -> reset_board 1-cycle pulse, IDLE, status=0, move_count=0, turn=0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the game turn controller: FSM state encoding,
// status codes and the auto-move LFSR polynomial.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_MOVE = 3'd1,
    S_INSERT    = 3'd2,
    S_CHECK     = 3'd3,
    S_GAME_OVER = 3'd4,
    S_CLEAR     = 3'd5
  } state_t;

  localparam logic [7:0] STATUS_NONE = 8'h00;
  localparam logic [7:0] STATUS_DRAW = 8'h0F;

  // x^8+x^6+x^5+x^4+1 as a left-shifting Fibonacci LFSR: taps on bits 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/game_turn_controller_if.sv
// Board / win-checker handshake bundle. master = turn controller, slave = board
// and win checker side.
interface game_turn_controller_if #(
  parameter int PID_W = 2,
  parameter int COL_W = 3
);
  // Handshake: a req is raised by the master and held steady (with its payload)
  // until the slave returns a single-cycle ack/done pulse; the qualifier
  // (insert_ok, win_flag/winner_id) is sampled only in that pulse cycle, and a
  // pulse arriving while req is low is ignored.
  logic             insert_req;
  logic [COL_W-1:0] insert_col;
  logic [PID_W-1:0] insert_player;
  logic             insert_ack;
  logic             insert_ok;
  logic             check_req;
  logic             check_done;
  logic             win_flag;
  logic [PID_W-1:0] winner_id;

  modport master (
    output insert_req, insert_col, insert_player, check_req,
    input  insert_ack, insert_ok, check_done, win_flag, winner_id
  );

  modport slave (
    input  insert_req, insert_col, insert_player, check_req,
    output insert_ack, insert_ok, check_done, win_flag, winner_id
  );
endinterface

// File: rtl/turn_timer.sv
// Per-turn countdown: prescaler counting clk ticks to one second, plus a
// seconds down-counter that raises a one-cycle timeout when it expires.
module turn_timer #(
  parameter int TURN_SECS     = 10,
  parameter int TICKS_PER_SEC = 50_000_000,
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       run,
  output logic [3:0] secs,
  output logic       timeout
);

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    secs_q, secs_d;
  logic          wrap;

  assign wrap    = run && (presc_q == PW'(TICKS_PER_SEC - 1));
  // Expiry is the second boundary reached while already showing zero
  assign timeout = wrap && (secs_q == 4'd0);
  assign secs    = secs_q;

  always_comb begin
    presc_d = presc_q;
    secs_d  = secs_q;
    if (load) begin
      presc_d = '0;
      secs_d  = 4'(TURN_SECS);
    end else if (run) begin
      presc_d = wrap ? '0 : presc_q + PW'(1);
      if (wrap && secs_q != 4'd0) secs_d = secs_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      secs_q  <= 4'(TURN_SECS);
    end else begin
      presc_q <= presc_d;
      secs_q  <= secs_d;
    end
  end

endmodule

// File: rtl/game_turn_controller.sv
// Round-robin board-game sequencer for NUM_PLAYERS players with per-turn timer
// and draw detection. Define GAME_AUTO_MOVE_EN to auto-insert on timeout.
module game_turn_controller
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS   = 2,
  parameter int COLS          = 7,
  parameter int ROWS          = 6,
  parameter int TURN_SECS     = 10,
  parameter int TICKS_PER_SEC = 50_000_000,
  localparam int PID_W = $clog2(NUM_PLAYERS + 1),
  localparam int COL_W = $clog2(COLS),
  localparam int MV_W  = $clog2(ROWS * COLS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             fsm_reset,
  input  logic             move_valid,
  input  logic [COL_W-1:0] move_col,
  game_turn_controller_if.master bus,
  output logic [PID_W-1:0] turn,
  output logic             enable_input,
  output logic [7:0]       status,
  output logic             game_over,
  output logic             reset_board,
  output logic [3:0]       seg_value,
  output logic             seg_enable,
  output logic [MV_W-1:0]  move_count,
  output state_t           state_dbg
);

  localparam logic [MV_W-1:0]  BOARD_CELLS = MV_W'(ROWS * COLS);
  localparam logic [PID_W-1:0] LAST_PID    = PID_W'(NUM_PLAYERS);

  state_t           state_q, state_d;
  logic [PID_W-1:0] turn_q, turn_d, next_pid;
  logic [COL_W-1:0] col_q, col_d;
  logic [7:0]       status_q, status_d;
  logic [MV_W-1:0]  mv_q, mv_d;
  logic             tmr_load, tmr_run, tmr_timeout;
  logic [3:0]       tmr_secs;

  turn_timer #(
    .TURN_SECS    (TURN_SECS),
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .run    (tmr_run),
    .secs   (tmr_secs),
    .timeout(tmr_timeout)
  );

  assign tmr_run  = (state_q == S_WAIT_MOVE);
  assign next_pid = (turn_q == LAST_PID) ? PID_W'(1) : turn_q + PID_W'(1);

`ifdef GAME_AUTO_MOVE_EN
  localparam int TRY_W = $clog2(COLS + 1);

  logic [7:0]       lfsr_q;
  logic [COL_W-1:0] lfsr_col;
  logic             auto_q, auto_d;
  logic [TRY_W-1:0] tries_q, tries_d;

  assign lfsr_col = COL_W'(lfsr_q % 8'(COLS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q  <= LFSR_SEED;
      auto_q  <= 1'b0;
      tries_q <= '0;
    end else begin
      lfsr_q  <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
      auto_q  <= auto_d;
      tries_q <= tries_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    turn_d   = turn_q;
    col_d    = col_q;
    status_d = status_q;
    mv_d     = mv_q;
    tmr_load = 1'b0;
`ifdef GAME_AUTO_MOVE_EN
    auto_d   = auto_q;
    tries_d  = tries_q;
`endif
    // Abort wins over everything; CLEAR itself always falls through to IDLE
    if (fsm_reset && state_q != S_IDLE && state_q != S_CLEAR) begin
      state_d  = S_CLEAR;
      turn_d   = '0;
      mv_d     = '0;
      status_d = STATUS_NONE;
      tmr_load = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !fsm_reset) begin
            state_d  = S_WAIT_MOVE;
            turn_d   = PID_W'(1);
            tmr_load = 1'b1;
          end
        end
        S_WAIT_MOVE: begin
          if (move_valid) begin
            col_d   = move_col;
            state_d = S_INSERT;
`ifdef GAME_AUTO_MOVE_EN
            auto_d  = 1'b0;
`endif
          end else if (tmr_timeout) begin
`ifdef GAME_AUTO_MOVE_EN
            col_d   = lfsr_col;
            auto_d  = 1'b1;
            tries_d = '0;
            state_d = S_INSERT;
`else
            turn_d   = next_pid;
            tmr_load = 1'b1;
`endif
          end
        end
        S_INSERT: begin
          if (bus.insert_ack) begin
            if (bus.insert_ok) begin
              mv_d    = mv_q + MV_W'(1);
              state_d = S_CHECK;
            end else begin
`ifdef GAME_AUTO_MOVE_EN
              // Automatic moves walk the columns; a full sweep means no space left
              if (auto_q) begin
                if (tries_q == TRY_W'(COLS - 1)) begin
                  status_d = STATUS_DRAW;
                  state_d  = S_GAME_OVER;
                end else begin
                  tries_d = tries_q + TRY_W'(1);
                  col_d   = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + COL_W'(1);
                end
              end else begin
                state_d = S_WAIT_MOVE;
              end
`else
              state_d = S_WAIT_MOVE;
`endif
            end
          end
        end
        S_CHECK: begin
          if (bus.check_done) begin
            if (bus.win_flag) begin
              status_d = 8'(bus.winner_id);
              state_d  = S_GAME_OVER;
            end else if (mv_q == BOARD_CELLS) begin
              status_d = STATUS_DRAW;
              state_d  = S_GAME_OVER;
            end else begin
              turn_d   = next_pid;
              tmr_load = 1'b1;
              state_d  = S_WAIT_MOVE;
            end
          end
        end
        S_GAME_OVER: state_d = S_GAME_OVER;
        S_CLEAR: begin
          state_d  = S_IDLE;
          tmr_load = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      turn_q   <= '0;
      col_q    <= '0;
      status_q <= STATUS_NONE;
      mv_q     <= '0;
    end else begin
      state_q  <= state_d;
      turn_q   <= turn_d;
      col_q    <= col_d;
      status_q <= status_d;
      mv_q     <= mv_d;
    end
  end

  assign bus.insert_req    = (state_q == S_INSERT);
  assign bus.insert_col    = col_q;
  assign bus.insert_player = turn_q;
  assign bus.check_req     = (state_q == S_CHECK);

  assign turn         = turn_q;
  assign enable_input = (state_q == S_WAIT_MOVE);
  assign seg_enable   = (state_q == S_WAIT_MOVE);
  assign seg_value    = (state_q == S_WAIT_MOVE) ? tmr_secs : 4'd0;
  assign status       = status_q;
  assign game_over    = (state_q == S_GAME_OVER);
  assign reset_board  = (state_q == S_CLEAR);
  assign move_count   = mv_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_game_turn_controller.sv
// Directed bench: DUT A (2 players, 7x6, 10 s) and DUT B (3 players, 2x2, 2 s),
// both with 4 clk ticks per second.
module tb_game_turn_controller;
  import game_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  // DUT A signals
  logic       a_start = 0, a_fsm_reset = 0, a_move_valid = 0;
  logic [2:0] a_move_col = 0;
  logic [1:0] a_turn;
  logic       a_en, a_go, a_rb, a_sege;
  logic [7:0] a_status;
  logic [3:0] a_seg;
  logic [5:0] a_mc;
  state_t     a_st;
  game_turn_controller_if #(.PID_W(2), .COL_W(3)) bus_a ();

  // DUT B signals
  logic       b_start = 0, b_fsm_reset = 0, b_move_valid = 0;
  logic [0:0] b_move_col = 0;
  logic [1:0] b_turn;
  logic       b_en, b_go, b_rb, b_sege;
  logic [7:0] b_status;
  logic [3:0] b_seg;
  logic [2:0] b_mc;
  state_t     b_st;
  game_turn_controller_if #(.PID_W(2), .COL_W(1)) bus_b ();

  game_turn_controller #(.NUM_PLAYERS(2), .COLS(7), .ROWS(6), .TURN_SECS(10), .TICKS_PER_SEC(4)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .fsm_reset(a_fsm_reset), .move_valid(a_move_valid),
    .move_col(a_move_col), .bus(bus_a), .turn(a_turn), .enable_input(a_en), .status(a_status),
    .game_over(a_go), .reset_board(a_rb), .seg_value(a_seg), .seg_enable(a_sege),
    .move_count(a_mc), .state_dbg(a_st)
  );

  game_turn_controller #(.NUM_PLAYERS(3), .COLS(2), .ROWS(2), .TURN_SECS(2), .TICKS_PER_SEC(4)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .fsm_reset(b_fsm_reset), .move_valid(b_move_valid),
    .move_col(b_move_col), .bus(bus_b), .turn(b_turn), .enable_input(b_en), .status(b_status),
    .game_over(b_go), .reset_board(b_rb), .seg_value(b_seg), .seg_enable(b_sege),
    .move_count(b_mc), .state_dbg(b_st)
  );

  initial begin
    bus_a.insert_ack = 0; bus_a.insert_ok = 0; bus_a.check_done = 0; bus_a.win_flag = 0; bus_a.winner_id = 0;
    bus_b.insert_ack = 0; bus_b.insert_ok = 0; bus_b.check_done = 0; bus_b.win_flag = 0; bus_b.winner_id = 0;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic a_pulse_start();
    a_start = 1; tick(1); a_start = 0;
  endtask
  task automatic a_move(input logic [2:0] c);
    a_move_col = c; a_move_valid = 1; tick(1); a_move_valid = 0;
  endtask
  task automatic a_ack(input logic ok);
    bus_a.insert_ack = 1; bus_a.insert_ok = ok; tick(1); bus_a.insert_ack = 0; bus_a.insert_ok = 0;
  endtask
  task automatic a_chk(input logic win, input logic [1:0] id);
    bus_a.check_done = 1; bus_a.win_flag = win; bus_a.winner_id = id; tick(1);
    bus_a.check_done = 0; bus_a.win_flag = 0; bus_a.winner_id = 0;
  endtask

  task automatic b_pulse_start();
    b_start = 1; tick(1); b_start = 0;
  endtask
  task automatic b_move(input logic [0:0] c);
    b_move_col = c; b_move_valid = 1; tick(1); b_move_valid = 0;
  endtask
  task automatic b_ack(input logic ok);
    bus_b.insert_ack = 1; bus_b.insert_ok = ok; tick(1); bus_b.insert_ack = 0; bus_b.insert_ok = 0;
  endtask
  task automatic b_chk(input logic win, input logic [1:0] id);
    bus_b.check_done = 1; bus_b.win_flag = win; bus_b.winner_id = id; tick(1);
    bus_b.check_done = 0; bus_b.win_flag = 0; bus_b.winner_id = 0;
  endtask
  task automatic b_abort();
    b_fsm_reset = 1; tick(1); b_fsm_reset = 0; tick(1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tick(2);
    checks++; if (a_st !== S_IDLE) begin failures++; $display("FAIL rst_state_a: got %0d want %0d", a_st, S_IDLE); end
    checks++; if (a_turn !== 2'd0) begin failures++; $display("FAIL rst_turn_a: got %0d want 0", a_turn); end
    checks++; if (a_status !== 8'h00) begin failures++; $display("FAIL rst_status_a: got %0h want 0", a_status); end
    checks++; if (a_mc !== 6'd0) begin failures++; $display("FAIL rst_mc_a: got %0d want 0", a_mc); end
    checks++; if ({a_en, a_go, a_rb, a_sege, bus_a.insert_req, bus_a.check_req} !== 6'b0) begin
      failures++; $display("FAIL rst_flags_a: got %b want 000000", {a_en, a_go, a_rb, a_sege, bus_a.insert_req, bus_a.check_req}); end
    checks++; if (a_seg !== 4'd0) begin failures++; $display("FAIL rst_seg_a: got %0d want 0", a_seg); end
    checks++; if (b_st !== S_IDLE || b_turn !== 2'd0) begin failures++; $display("FAIL rst_b: got state %0d turn %0d want 0 0", b_st, b_turn); end
    rst = 1;
    tick(1);
    checks++; if (a_st !== S_IDLE) begin failures++; $display("FAIL idle_hold_a: got %0d want %0d", a_st, S_IDLE); end
  endtask

  task automatic test_first_move();
    a_pulse_start();
    checks++; if (a_turn !== 2'd1) begin failures++; $display("FAIL start_turn: got %0d want 1", a_turn); end
    checks++; if (a_en !== 1'b1 || a_sege !== 1'b1) begin failures++; $display("FAIL start_enable: got %b%b want 11", a_en, a_sege); end
    checks++; if (a_seg !== 4'd10) begin failures++; $display("FAIL start_seg: got %0d want 10", a_seg); end
    a_move(3'd3);
    checks++; if (bus_a.insert_req !== 1'b1) begin failures++; $display("FAIL move_req_latency: got %b want 1", bus_a.insert_req); end
    checks++; if (bus_a.insert_col !== 3'd3) begin failures++; $display("FAIL move_col: got %0d want 3", bus_a.insert_col); end
    checks++; if (bus_a.insert_player !== 2'd1) begin failures++; $display("FAIL move_player: got %0d want 1", bus_a.insert_player); end
    checks++; if (a_en !== 1'b0 || a_seg !== 4'd0) begin failures++; $display("FAIL insert_disp: got en %b seg %0d want 0 0", a_en, a_seg); end
    a_move(3'd5);
    checks++; if (bus_a.insert_col !== 3'd3 || a_st !== S_INSERT) begin
      failures++; $display("FAIL extra_move_ignored: got col %0d state %0d want 3 %0d", bus_a.insert_col, a_st, S_INSERT); end
    a_ack(1'b1);
    checks++; if (bus_a.check_req !== 1'b1 || bus_a.insert_req !== 1'b0) begin
      failures++; $display("FAIL ack_to_check: got chk %b ins %b want 1 0", bus_a.check_req, bus_a.insert_req); end
    checks++; if (a_mc !== 6'd1) begin failures++; $display("FAIL move_count_1: got %0d want 1", a_mc); end
    a_chk(1'b0, 2'd0);
    checks++; if (a_turn !== 2'd2) begin failures++; $display("FAIL next_turn: got %0d want 2", a_turn); end
    checks++; if (a_en !== 1'b1) begin failures++; $display("FAIL check_to_enable: got %b want 1", a_en); end
    checks++; if (a_seg !== 4'd10) begin failures++; $display("FAIL reload_seg: got %0d want 10", a_seg); end
    checks++; if (bus_a.insert_col !== 3'd3) begin failures++; $display("FAIL col_held: got %0d want 3", bus_a.insert_col); end
  endtask

  task automatic test_insert_fail();
    tick(20);
    checks++; if (a_seg !== 4'd5) begin failures++; $display("FAIL countdown_5: got %0d want 5", a_seg); end
    a_move(3'd4);
    checks++; if (a_st !== S_INSERT || bus_a.insert_player !== 2'd2) begin
      failures++; $display("FAIL p2_insert: got state %0d player %0d want %0d 2", a_st, bus_a.insert_player, S_INSERT); end
    a_ack(1'b0);
    checks++; if (a_st !== S_WAIT_MOVE) begin failures++; $display("FAIL full_col_state: got %0d want %0d", a_st, S_WAIT_MOVE); end
    checks++; if (a_turn !== 2'd2) begin failures++; $display("FAIL full_col_turn: got %0d want 2", a_turn); end
    checks++; if (a_seg !== 4'd5) begin failures++; $display("FAIL full_col_seg: got %0d want 5", a_seg); end
    checks++; if (a_mc !== 6'd1) begin failures++; $display("FAIL full_col_mc: got %0d want 1", a_mc); end
  endtask

  task automatic test_reset_in_insert();
    a_move(3'd0);
    a_fsm_reset = 1;
    tick(1);
    checks++; if (a_st !== S_CLEAR || a_rb !== 1'b1) begin failures++; $display("FAIL ins_clear: got state %0d rb %b want %0d 1", a_st, a_rb, S_CLEAR); end
    checks++; if (a_turn !== 2'd0 || a_mc !== 6'd0) begin failures++; $display("FAIL ins_clear_vals: got turn %0d mc %0d want 0 0", a_turn, a_mc); end
    checks++; if (bus_a.insert_req !== 1'b0) begin failures++; $display("FAIL ins_clear_req: got %b want 0", bus_a.insert_req); end
    tick(1);
    checks++; if (a_st !== S_IDLE || a_rb !== 1'b0) begin failures++; $display("FAIL ins_idle: got state %0d rb %b want %0d 0", a_st, a_rb, S_IDLE); end
    a_start = 1;
    tick(1);
    checks++; if (a_st !== S_IDLE) begin failures++; $display("FAIL held_reset_idle: got %0d want %0d", a_st, S_IDLE); end
    a_start = 0; a_fsm_reset = 0;
  endtask

  task automatic test_game_over_reset();
    a_pulse_start();
    a_move(3'd6);
    a_ack(1'b1);
    a_chk(1'b1, 2'd2);
    checks++; if (a_status !== 8'h02 || a_go !== 1'b1) begin failures++; $display("FAIL win_a: got status %0h go %b want 02 1", a_status, a_go); end
    tick(3);
    checks++; if (a_status !== 8'h02 || a_go !== 1'b1 || a_en !== 1'b0) begin
      failures++; $display("FAIL win_hold: got status %0h go %b en %b want 02 1 0", a_status, a_go, a_en); end
    a_fsm_reset = 1; tick(1); a_fsm_reset = 0;
    checks++; if (a_rb !== 1'b1 || a_status !== 8'h00 || a_go !== 1'b0) begin
      failures++; $display("FAIL go_clear: got rb %b status %0h go %b want 1 00 0", a_rb, a_status, a_go); end
    tick(1);
    checks++; if (a_rb !== 1'b0 || a_st !== S_IDLE) begin failures++; $display("FAIL go_idle: got rb %b state %0d want 0 %0d", a_rb, a_st, S_IDLE); end
    checks++; if (a_mc !== 6'd0 || a_turn !== 2'd0 || a_status !== 8'h00) begin
      failures++; $display("FAIL go_idle_vals: got mc %0d turn %0d status %0h want 0 0 00", a_mc, a_turn, a_status); end
  endtask

  task automatic test_timeout();
    b_pulse_start();
    checks++; if (b_seg !== 4'd2 || b_turn !== 2'd1) begin failures++; $display("FAIL to_start: got seg %0d turn %0d want 2 1", b_seg, b_turn); end
    tick(11);
    checks++; if (b_turn !== 2'd1 || b_seg !== 4'd0 || b_en !== 1'b1) begin
      failures++; $display("FAIL to_before: got turn %0d seg %0d en %b want 1 0 1", b_turn, b_seg, b_en); end
    tick(1);
`ifdef GAME_AUTO_MOVE_EN
    checks++; if (bus_b.insert_req !== 1'b1 || bus_b.insert_player !== 2'd1) begin
      failures++; $display("FAIL to_auto: got req %b player %0d want 1 1", bus_b.insert_req, bus_b.insert_player); end
    b_ack(1'b1);
    b_chk(1'b0, 2'd0);
    checks++; if (b_turn !== 2'd2 || b_mc !== 3'd1) begin failures++; $display("FAIL to_auto_after: got turn %0d mc %0d want 2 1", b_turn, b_mc); end
`else
    checks++; if (b_turn !== 2'd2 || b_mc !== 3'd0) begin failures++; $display("FAIL to_skip: got turn %0d mc %0d want 2 0", b_turn, b_mc); end
    checks++; if (b_seg !== 4'd2 || b_st !== S_WAIT_MOVE) begin
      failures++; $display("FAIL to_reload: got seg %0d state %0d want 2 %0d", b_seg, b_st, S_WAIT_MOVE); end
`endif
    b_abort();
  endtask

  task automatic test_move_beats_timeout();
    b_pulse_start();
    tick(11);
    b_move(1'b1);
    checks++; if (b_st !== S_INSERT || bus_b.insert_col !== 1'b1 || bus_b.insert_player !== 2'd1) begin
      failures++; $display("FAIL move_vs_timeout: got state %0d col %0d player %0d want %0d 1 1", b_st, bus_b.insert_col, bus_b.insert_player, S_INSERT); end
    b_abort();
  endtask

  task automatic test_rotation();
    logic [1:0] exp;
    b_pulse_start();
    exp_q.push_back(2'd2); exp_q.push_back(2'd3); exp_q.push_back(2'd1);
    for (int i = 0; i < 3; i++) begin
      b_move(1'(i));
      b_ack(1'b1);
      b_chk(1'b0, 2'd0);
      exp = exp_q.pop_front();
      checks++; if (b_turn !== exp) begin failures++; $display("FAIL rotation_%0d: got %0d want %0d", i, b_turn, exp); end
    end
    b_move(1'b0);
    b_ack(1'b1);
    b_chk(1'b1, 2'd3);
    checks++; if (b_status !== 8'h03 || b_go !== 1'b1) begin failures++; $display("FAIL win_p3: got status %0h go %b want 03 1", b_status, b_go); end
    b_abort();
  endtask

  task automatic test_draw();
    b_pulse_start();
    for (int i = 0; i < 3; i++) begin
      b_move(1'(i));
      b_ack(1'b1);
      b_chk(1'b0, 2'd0);
    end
    checks++; if (b_go !== 1'b0 || b_mc !== 3'd3 || b_turn !== 2'd1) begin
      failures++; $display("FAIL pre_draw: got go %b mc %0d turn %0d want 0 3 1", b_go, b_mc, b_turn); end
    b_move(1'b1);
    b_ack(1'b1);
    b_chk(1'b0, 2'd0);
    checks++; if (b_status !== 8'h0F || b_go !== 1'b1 || b_mc !== 3'd4) begin
      failures++; $display("FAIL draw: got status %0h go %b mc %0d want 0f 1 4", b_status, b_go, b_mc); end
  endtask

  initial begin
    test_reset();
    test_first_move();
    test_insert_fail();
    test_reset_in_insert();
    test_game_over_reset();
    test_timeout();
    test_move_beats_timeout();
    test_rotation();
    test_draw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
